// File: rtl/fetch_unit_pkg.sv
// Shared constants for the microcpu instruction-fetch front end.
//   ADDR_W / DATA_W : default PC and instruction widths
//   PC_INCR         : byte stride between sequential instruction words
//   RESET_PC_DEF    : default PC loaded on reset
//   NOP             : word presented on inst_data while the queue is empty
package fetch_unit_pkg;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int PC_INCR = 4;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = '0;
  localparam logic [DATA_W-1:0] NOP          = 32'h0000_0013;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO used for the prefetch data queue and the in-flight PC tag queue.
//   clk, reset     : clock, synchronous active-high reset
//   push/push_data : write an entry at the tail
//   pop            : drop the head entry (caller never pops when empty)
//   flush          : empty the queue at this edge; overrides push and pop
//   head_data      : current head entry
//   count, empty   : occupancy
// A push and a pop in the same cycle both take effect, even when full: the
// write lands in the slot the pop is vacating.
import fetch_unit_pkg::*;

module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]               wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]               cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_data = mem_q[rd_q];
  assign count     = cnt_q;
  assign empty     = (cnt_q == '0);
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word reads over a
// req/gnt/rvalid handshake, buffers returned words and presents them to decode.
//   clk, reset                  : clock, synchronous active-high reset
//   enable                      : allow new fetches to issue
//   redirect_valid/redirect_pc  : one-cycle PC load + flush
//   imem_req/addr/gnt           : request channel to instruction memory
//   imem_rvalid/rdata           : in-order response channel
//   inst_valid/ready/data/pc    : head of the prefetch queue to decode
// Queue occupancy plus outstanding requests never exceeds DEPTH, so responses
// always have a slot. Responses for requests issued before a redirect are
// counted in stale_q and dropped as they return.
import fetch_unit_pkg::*;

module fetch_unit #(
  parameter int                    ADDR_WIDTH = ADDR_W,
  parameter int                    DATA_WIDTH = DATA_W,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [CW-1:0]         stale_q, stale_d;

  logic                  grant, use_rsp, pop, credit_ok;
  logic [CW-1:0]         dq_count;
  logic                  dq_empty;
  logic [DATA_WIDTH+ADDR_WIDTH-1:0] dq_head;
  logic [ADDR_WIDTH-1:0] tag_pc;
  logic [CW-1:0]         unused_tq_count;
  logic                  unused_tq_empty;
  logic                  unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign credit_ok = ({1'b0, dq_count} + {1'b0, inflight_q}) < (CW+1)'(DEPTH);
  assign imem_req  = ~reset & enable & ~redirect_valid & credit_ok;
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req & imem_gnt;
  // A response is kept only if it was issued after the last redirect and
  // does not coincide with a new redirect.
  assign use_rsp   = imem_rvalid & ~redirect_valid & (stale_q == '0);
  assign pop       = inst_valid & inst_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)  fetch_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    else if (grant)      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(PC_INCR);

    inflight_d = inflight_q + CW'(grant) - CW'(imem_rvalid);

    stale_d = stale_q;
    // Everything still outstanding after this cycle belongs to the old path,
    // including responses already marked stale by an earlier redirect.
    if (redirect_valid)                     stale_d = inflight_q - CW'(imem_rvalid);
    else if (imem_rvalid && stale_q != '0)  stale_d = stale_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      stale_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
    end
  end

  // PC of each granted request, consumed in order by its response.
  fetch_queue #(.WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_tag_q (
    .clk       (clk),
    .reset     (reset),
    .push      (grant),
    .push_data (fetch_pc_q),
    .pop       (use_rsp),
    .flush     (redirect_valid),
    .head_data (tag_pc),
    .count     (unused_tq_count),
    .empty     (unused_tq_empty)
  );

  fetch_queue #(.WIDTH(DATA_WIDTH+ADDR_WIDTH), .DEPTH(DEPTH)) u_data_q (
    .clk       (clk),
    .reset     (reset),
    .push      (use_rsp),
    .push_data ({imem_rdata, tag_pc}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (dq_head),
    .count     (dq_count),
    .empty     (dq_empty)
  );

  assign inst_valid = ~reset & ~dq_empty;
  assign inst_data  = reset    ? '0 :
                      dq_empty ? DATA_WIDTH'(NOP) :
                                 dq_head[DATA_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
  assign inst_pc    = reset ? '0 : dq_head[ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset, enable, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;

  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend[$];
  logic [31:0] pops[$];
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0, lat = 1, n_gnt = 0, first_gnt = -1, first_vld = -1;
  bit          rnd_lat = 0;
  logic [31:0] exp_pc = '0;
  logic        last_req, last_valid;
  logic [31:0] last_addr, last_pc;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 3) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic tick();
    int l;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mdata(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    last_req = imem_req; last_addr = imem_addr; last_valid = inst_valid; last_pc = inst_pc;
    if (imem_req && imem_gnt) begin
      l = rnd_lat ? int'($urandom_range(1, 4)) : lat;
      n_gnt++;
      if (first_gnt < 0) first_gnt = cyc;
      pend.push_back('{imem_addr, cyc + l});
    end
    if (inst_valid && first_vld < 0) first_vld = cyc;
    if (inst_valid && inst_ready) begin
      pops.push_back(inst_pc);
      chk("sb_pc", inst_pc, exp_pc);
      chk("sb_data", inst_data, mdata(inst_pc));
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    inst_ready = 1'b0; imem_gnt = 1'b1; rnd_lat = 0;
    pend.delete();
    tick(); tick();
    chk("rst_req", last_req, 0);
    chk("rst_valid", last_valid, 0);
    chk("rst_addr", last_addr, 32'h0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    reset = 1'b0;
    pend.delete(); pops.delete();
    exp_pc = '0; n_gnt = 0; cyc = 0; first_gnt = -1; first_vld = -1;
  endtask

  initial begin
    int g0, bad_head;
    imem_rvalid = 1'b0; imem_rdata = '0;

    // Streaming with a 1-cycle memory.
    do_reset(); lat = 1; inst_ready = 1'b1;
    repeat (10) tick();
    chk("lat_gnt_to_valid", first_vld - first_gnt, 2);
    chk("stream_pop_count", pops.size(), 8);

    // Backpressure: queue fills, requests stop, head holds.
    do_reset(); lat = 1; inst_ready = 1'b0; bad_head = 0;
    repeat (10) begin
      tick();
      if (last_valid && last_pc !== 32'h0) bad_head++;
    end
    chk("bp_grants", n_gnt, 4);
    chk("bp_req_low", last_req, 0);
    chk("bp_valid", inst_valid, 1);
    chk("bp_head_pc", inst_pc, 32'h0);
    chk("bp_head_data", inst_data, mdata(32'h0));
    chk("bp_head_stable", bad_head, 0);
    inst_ready = 1'b1;
    repeat (8) tick();
    chk("bp_drain_count", pops.size(), 8);

    // Redirect with 3 in flight, 3-cycle memory.
    do_reset(); lat = 3; inst_ready = 1'b1;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    chk("rd_req_low", last_req, 0);
    redirect_valid = 1'b0;
    repeat (14) tick();
    chk("rd_have_pops", pops.size() >= 2, 1);
    if (pops.size() >= 2) begin
      chk("rd_first_pc", pops[0], 32'h40);
      chk("rd_second_pc", pops[1], 32'h44);
    end

    // Misaligned redirect coinciding with pop and rvalid.
    do_reset(); lat = 1; inst_ready = 1'b1;
    repeat (5) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    tick();
    chk("sim_pop_in_redirect", last_valid, 1);
    redirect_valid = 1'b0;
    tick();
    chk("sim_flush_empty", last_valid, 0);
    chk("sim_addr_aligned", last_addr, 32'h40);
    repeat (6) tick();
    chk("sim_pop_count", pops.size(), 9);
    if (pops.size() >= 6) begin
      chk("sim_last_old_pc", pops[3], 32'hC);
      chk("sim_new_pc0", pops[4], 32'h40);
      chk("sim_new_pc1", pops[5], 32'h44);
    end

    // enable drop mid-stream.
    do_reset(); lat = 2; inst_ready = 1'b1;
    repeat (4) tick();
    enable = 1'b0; g0 = n_gnt;
    repeat (8) tick();
    chk("en_no_grant", n_gnt - g0, 0);
    chk("en_req_low", last_req, 0);
    chk("en_inflight_delivered", pops.size(), g0);
    enable = 1'b1;
    tick();
    chk("en_resume_req", last_req, 1);
    chk("en_resume_addr", last_addr, 32'(g0 * 4));
    repeat (10) tick();

    // Random handshakes and redirects, checked by the scoreboard in tick().
    do_reset(); rnd_lat = 1;
    repeat (600) begin
      imem_gnt       = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 3) != 0);
      enable         = ($urandom_range(0, 7) != 0);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = $urandom & 32'h0000_0FFF;
      tick();
    end
    chk("rnd_progress", pops.size() > 50, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end
endmodule
